// File: rtl/msg_pkg.sv
// Shared definitions for the message streamer: entry width, terminator code,
// default XOR key, FSM state encoding and the ROM entry decoder.
package msg_pkg;

    localparam int unsigned    MSG_W           = 9;
    localparam logic [8:0]     TERM            = 9'h1FF;
    localparam logic [7:0]     KEY_DEFAULT     = 8'hFF;
    localparam int unsigned    MAX_LEN_DEFAULT = 511;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StEmit,
        StDone
    } state_e;

    typedef struct packed {
        logic       is_term;
        logic [7:0] data;
    } decode_t;

    // TERM wins over the key bit, so 0x1FF is never decoded as a byte.
    function automatic decode_t decode_entry(input logic [MSG_W-1:0] v, input logic [7:0] key);
        decode_t d;
        d.is_term = (v == TERM);
        d.data    = v[MSG_W-1] ? (v[7:0] ^ key) : v[7:0];
        return d;
    endfunction

endpackage

// File: rtl/message_streamer_if.sv
// ROM lookup and byte-stream handshake bundle for the message streamer.
//   rom_ptr   : streamer -> LUT, entry address
//   rom_value : LUT -> streamer, entry data for rom_ptr (same cycle)
//   tx_data   : streamer -> sink, decoded byte
//   tx_valid  : streamer -> sink, tx_data valid
//   tx_ready  : sink -> streamer, byte accepted when tx_valid && tx_ready
// master = streamer side, slave = LUT/sink side.
interface message_streamer_if;
    import msg_pkg::*;

    logic [MSG_W-1:0] rom_ptr;
    logic [MSG_W-1:0] rom_value;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;

    modport master (
        output rom_ptr,
        input  rom_value,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  rom_ptr,
        output rom_value,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/message_streamer.sv
// Sequential reader for the 9-bit message ROM. Walks rom_ptr from 0, decodes
// each entry and streams bytes over a valid/ready interface until the
// terminator (or the end-of-ROM pointer) is reached.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : pulse, begin streaming from pointer 0 (ignored while busy)
//   abort       : pulse, return to idle immediately (beats start)
//   bus         : ROM lookup + byte handshake (master modport)
//   busy        : high in fetch/emit
//   done        : level, stream finished; cleared by start/abort
//   overflow    : level, end-of-ROM reached without terminator
//   byte_count  : bytes accepted since the last start (saturating)
module message_streamer
    import msg_pkg::*;
#(
    parameter logic [7:0]  KEY     = KEY_DEFAULT,
    parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    message_streamer_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [MSG_W-1:0]    byte_count
);

    localparam logic [MSG_W-1:0] PTR_LAST = MSG_W'(MAX_LEN);

    state_e           state;
    logic [MSG_W-1:0] rom_ptr;
    logic [7:0]       tx_data;
    logic             tx_valid;
    decode_t          dec;
    logic             advance;

    assign bus.rom_ptr  = rom_ptr;
    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;

    assign dec = decode_entry(bus.rom_value, KEY);

    // FETCH always consumes the current entry; EMIT only once the held byte
    // is accepted, which lets the next byte load in the handshake cycle.
    assign advance = (state == StFetch) || ((state == StEmit) && bus.tx_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            rom_ptr    <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
        end else if (abort) begin
            state    <= StIdle;
            rom_ptr  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state      <= StFetch;
                        rom_ptr    <= '0;
                        byte_count <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        overflow   <= 1'b0;
                    end
                end
                StFetch, StEmit: begin
                    if (advance) begin
                        if ((state == StEmit) && (byte_count != PTR_LAST)) begin
                            byte_count <= byte_count + 1'b1;
                        end
                        if (dec.is_term || (rom_ptr == PTR_LAST)) begin
                            state    <= StDone;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            overflow <= !dec.is_term;
                        end else begin
                            state    <= StEmit;
                            tx_data  <= dec.data;
                            tx_valid <= 1'b1;
                            rom_ptr  <= rom_ptr + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_message_streamer.sv
// Self-checking bench for message_streamer: ROM model, scoreboard queue of
// expected bytes filled at stimulus time, and a monitor that pops on every
// handshake.
module tb_message_streamer;
    import msg_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic       overflow;
    logic [8:0] byte_count;

    message_streamer_if bus();

    message_streamer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    logic [8:0] rom [512];
    assign bus.rom_value = rom[bus.rom_ptr];

    logic [7:0] msg_bytes [15] = '{8'h4E, 8'h6F, 8'h74, 8'h20, 8'h73, 8'h6F, 8'h20, 8'h65,
                                   8'h61, 8'h73, 8'h79, 8'h21, 8'h20, 8'h3B, 8'h50};

    int         checks = 0;
    int         passed = 0;
    logic [7:0] exp_q [$];
    int         ready_mode = 0;
    logic       man_ready = 1'b1;
    int         cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Sink ready pattern, applied 2 time units after each rising edge.
    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            case (ready_mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = ((cyc % 3) == 0);
                2:       bus.tx_ready = 1'($urandom_range(0, 1));
                default: bus.tx_ready = man_ready;
            endcase
        end
    end

    // Monitor: pop and compare on each handshake, check hold while stalled.
    logic [7:0] held = '0;
    bit         stall_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev && bus.tx_valid) chk("stall_stable", 32'(bus.tx_data), 32'(held));
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) chk("unexpected_byte", 32'(exp_q.size()), 32'd1);
                else chk("byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
            stall_prev = bus.tx_valid && !bus.tx_ready && !abort;
            held       = bus.tx_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 512; i++) rom[i] = TERM;
    endtask

    // Message ROM: even entries literal, odd entries key-encoded.
    task automatic load_msg();
        clear_rom();
        for (int i = 0; i < 15; i++) begin
            if (i % 2 == 1) rom[i] = {1'b1, msg_bytes[i] ^ 8'hFF};
            else            rom[i] = {1'b0, msg_bytes[i]};
        end
    endtask

    task automatic push_msg();
        for (int i = 0; i < 15; i++) exp_q.push_back(msg_bytes[i]);
    endtask

    // Reference: walk the ROM from 0, stop on TERM or at pointer 511.
    task automatic model(output int n, output int ptr, output bit ovf);
        int         p;
        logic [8:0] v;
        n   = 0;
        ovf = 1'b0;
        p   = 0;
        while (1) begin
            v = rom[p];
            if (v == 9'h1FF) break;
            if (p == 511) begin
                ovf = 1'b1;
                break;
            end
            if (v >= 9'h100) exp_q.push_back(8'(v - 9'h100) ^ 8'hFF);
            else             exp_q.push_back(8'(v));
            n++;
            p++;
        end
        ptr = p;
    endtask

    task automatic run(input int mode, input int restart_at, input int exp_n, input int exp_ptr,
                       input bit exp_ovf);
        bit seen = 1'b0;
        ready_mode = mode;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("no_valid_n_plus_1", 32'(bus.tx_valid), 32'd0);
        for (int k = 0; k < 3000; k++) begin
            start = 1'b0;
            if (k == 1) begin
                if (exp_n > 0) chk("valid_n_plus_2", 32'(bus.tx_valid), 32'd1);
                else           chk("done_n_plus_2", 32'(done), 32'd1);
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (k == restart_at) start = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("done_reached", 32'(seen), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("byte_count", 32'(byte_count), 32'(exp_n));
        chk("rom_ptr_end", 32'(bus.rom_ptr), 32'(exp_ptr));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("busy_end", 32'(busy), 32'd0);
        chk("valid_end", 32'(bus.tx_valid), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        int ptr;
        bit ovf;
        bit hit;

        clear_rom();
        #12;
        chk("rst_rom_ptr", 32'(bus.rom_ptr), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_byte_count", 32'(byte_count), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Real message, sink always ready.
        load_msg();
        push_msg();
        run(0, -1, 15, 15, 1'b0);
        chk("done_level", 32'(done), 32'd1);

        // Same message, sink ready one cycle in three.
        push_msg();
        run(1, -1, 15, 15, 1'b0);

        // Terminator at entry 0.
        clear_rom();
        run(0, -1, 0, 0, 1'b0);

        // No terminator anywhere.
        for (int i = 0; i < 512; i++) rom[i] = 9'h041;
        model(n, ptr, ovf);
        run(0, -1, n, ptr, ovf);
        chk("ovf_len", 32'(n), 32'd511);

        // Abort while the 6th byte is stalled.
        load_msg();
        push_msg();
        ready_mode = 3;
        man_ready  = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (byte_count == 9'd5) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("abort_reach5", 32'(hit), 32'd1);
        man_ready = 1'b0;
        chk("abort_pre_valid", 32'(bus.tx_valid), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_valid", 32'(bus.tx_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ptr", 32'(bus.rom_ptr), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 chk("idle_after_abort", 32'(bus.tx_valid), 32'd0);
        push_msg();
        run(0, -1, 15, 15, 1'b0);

        // Asynchronous reset mid-stream.
        push_msg();
        ready_mode = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rom_ptr", 32'(bus.rom_ptr), 32'd0);
        chk("arst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_byte_count", 32'(byte_count), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;

        // start during EMIT is ignored.
        push_msg();
        run(1, 6, 15, 15, 1'b0);

        // Random ROM contents and sink patterns.
        for (int t = 0; t < 6; t++) begin
            clear_rom();
            for (int i = 0; i < int'($urandom_range(1, 40)); i++) begin
                if ($urandom_range(0, 7) == 0) rom[i] = 9'h000;
                else                           rom[i] = 9'($urandom_range(0, 510));
            end
            model(n, ptr, ovf);
            run(int'($urandom_range(0, 2)), -1, n, ptr, ovf);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
